// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu
// Load/store initiator for the MEM stage. Converts the EX/MEM register's
// single-cycle mem_read/mem_write into a valid/ready request followed by a
// single-pulse response on a multi-cycle word data memory. lsu_stall freezes
// the upstream pipeline while an access is in flight. Misaligned,
// out-of-range, errored and timed-out accesses are reported on access_fault.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   mem_read, mem_write         EX/MEM access controls
//   address, write_data         EX/MEM ALU result and store data
//   lsu_stall                   freeze PC, IF/ID, ID/EX, EX/MEM
//   load_data                   read data to the mem_to_reg mux (held)
//   load_valid, access_fault    one-cycle completion pulses (DONE cycle)
//   bus_req_valid/ready         request handshake
//   bus_req_we/addr/wdata       request payload, stable until handshake
//   bus_resp_valid/rdata/err    single-cycle response, no back-pressure
module mem_stage_lsu #(
    parameter int MEM_BYTES      = 128,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic        lsu_stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        access_fault,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic        bus_req_we,
    output logic [31:0] bus_req_addr,
    output logic [31:0] bus_req_wdata,
    input  logic        bus_resp_valid,
    input  logic [31:0] bus_resp_rdata,
    input  logic        bus_resp_err
);

    // Counter must hold TIMEOUT_CYCLES: a handshake on the last allowed edge
    // pushes it one past TIMEOUT_CYCLES-1 before the RESP-side timeout fires.
    localparam int               CNT_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0]      ADDR_LIMIT = 32'(MEM_BYTES);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_valid_q, req_valid_d;
    logic             req_we_q, req_we_d;
    logic [31:0]      req_addr_q, req_addr_d;
    logic [31:0]      req_wdata_q, req_wdata_d;
    logic [31:0]      load_data_q, load_data_d;
    logic             load_valid_q, load_valid_d;
    logic             access_fault_q, access_fault_d;

    logic access_req;
    logic illegal;
    logic handshake;
    logic timed_out;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        req_valid_d    = req_valid_q;
        req_we_d       = req_we_q;
        req_addr_d     = req_addr_q;
        req_wdata_d    = req_wdata_q;
        load_data_d    = load_data_q;
        load_valid_d   = 1'b0;
        access_fault_d = 1'b0;
        lsu_stall      = 1'b0;

        access_req = mem_read | mem_write;
        illegal    = (mem_read & mem_write) | (address[1:0] != 2'b00) |
                     (address >= ADDR_LIMIT);
        handshake  = req_valid_q & bus_req_ready;
        timed_out  = (cnt_q >= CNT_LAST);

        case (state_q)
            IDLE: begin
                if (access_req) begin
                    // Stall in the detect cycle, faulting or not, so the
                    // instruction is held until its DONE cycle.
                    lsu_stall = 1'b1;
                    if (illegal) begin
                        access_fault_d = 1'b1;
                        load_data_d    = 32'd0;
                        state_d        = DONE;
                    end else begin
                        req_addr_d  = {address[31:2], 2'b00};
                        req_wdata_d = write_data;
                        req_we_d    = mem_write;
                        req_valid_d = 1'b1;
                        cnt_d       = '0;
                        state_d     = REQ;
                    end
                end
            end
            REQ: begin
                lsu_stall = 1'b1;
                cnt_d     = cnt_q + CNT_W'(1);
                if (handshake) begin
                    req_valid_d = 1'b0;
                    state_d     = RESP;
                end else if (timed_out) begin
                    req_valid_d    = 1'b0;
                    access_fault_d = 1'b1;
                    load_data_d    = 32'd0;
                    state_d        = DONE;
                end
            end
            RESP: begin
                lsu_stall = 1'b1;
                cnt_d     = cnt_q + CNT_W'(1);
                // A response on the timeout edge takes priority.
                if (bus_resp_valid) begin
                    state_d = DONE;
                    if (bus_resp_err) begin
                        access_fault_d = 1'b1;
                        load_data_d    = 32'd0;
                    end else if (!req_we_q) begin
                        load_data_d  = bus_resp_rdata;
                        load_valid_d = 1'b1;
                    end
                end else if (timed_out) begin
                    access_fault_d = 1'b1;
                    load_data_d    = 32'd0;
                    state_d        = DONE;
                end
            end
            DONE: begin
                // Inputs are not looked at here: the pipeline still shows the
                // completed instruction this cycle and must not re-issue it.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (reset) begin
            lsu_stall = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            req_valid_q    <= 1'b0;
            req_we_q       <= 1'b0;
            req_addr_q     <= 32'd0;
            req_wdata_q    <= 32'd0;
            load_data_q    <= 32'd0;
            load_valid_q   <= 1'b0;
            access_fault_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            req_valid_q    <= req_valid_d;
            req_we_q       <= req_we_d;
            req_addr_q     <= req_addr_d;
            req_wdata_q    <= req_wdata_d;
            load_data_q    <= load_data_d;
            load_valid_q   <= load_valid_d;
            access_fault_q <= access_fault_d;
        end
    end

    assign bus_req_valid = req_valid_q;
    assign bus_req_we    = req_we_q;
    assign bus_req_addr  = req_addr_q;
    assign bus_req_wdata = req_wdata_q;
    assign load_data     = load_data_q;
    assign load_valid    = load_valid_q;
    assign access_fault  = access_fault_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Testbench for mem_stage_lsu: directed accesses with a responder model in
// the stimulus process and a scoreboard monitor checking each completion.
module tb_mem_stage_lsu;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read, mem_write;
    logic [31:0] address, write_data;
    logic        lsu_stall;
    logic [31:0] load_data;
    logic        load_valid, access_fault;
    logic        bus_req_valid, bus_req_ready, bus_req_we;
    logic [31:0] bus_req_addr, bus_req_wdata;
    logic        bus_resp_valid;
    logic [31:0] bus_resp_rdata;
    logic        bus_resp_err;

    always #5 clk = ~clk;

    mem_stage_lsu #(.MEM_BYTES(128), .TIMEOUT_CYCLES(T)) dut (
        .clk           (clk),
        .reset         (reset),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .address       (address),
        .write_data    (write_data),
        .lsu_stall     (lsu_stall),
        .load_data     (load_data),
        .load_valid    (load_valid),
        .access_fault  (access_fault),
        .bus_req_valid (bus_req_valid),
        .bus_req_ready (bus_req_ready),
        .bus_req_we    (bus_req_we),
        .bus_req_addr  (bus_req_addr),
        .bus_req_wdata (bus_req_wdata),
        .bus_resp_valid(bus_resp_valid),
        .bus_resp_rdata(bus_resp_rdata),
        .bus_resp_err  (bus_resp_err)
    );

    typedef struct packed {
        logic        valid;
        logic        fault;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    logic prev_stall = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic expect_done(input logic v, input logic f, input logic [31:0] d);
        exp_t e;
        e.valid = v;
        e.fault = f;
        e.data  = d;
        exp_q.push_back(e);
    endtask

    // Completion monitor: a DONE cycle is the first non-stalled cycle after a
    // stalled one; any stray load_valid/access_fault pulse is also caught.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && ((prev_stall && !lsu_stall) || load_valid || access_fault)) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_completion: got valid=%0b fault=%0b data=%0h expected none",
                         load_valid, access_fault, load_data);
            end else begin
                e = exp_q.pop_front();
                check("completion", 64'({load_valid, access_fault, load_data}),
                      64'({e.valid, e.fault, e.data}));
            end
        end
        prev_stall <= lsu_stall;
    end

    // Drives one access and plays the memory: ready after ready_dly cycles of
    // bus_req_valid, optional response the cycle after the handshake.
    task automatic run_access(input logic rd, input logic wr,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input int ready_dly, input bit resp_en, input bit resp_err,
                              input logic [31:0] rdata,
                              output int stall_cyc, output int hs_cnt,
                              output int reqv_cyc, output bit stable_ok);
        int  hs_at;
        bit  done;
        stall_cyc = 0;
        hs_cnt    = 0;
        reqv_cyc  = 0;
        stable_ok = 1'b1;
        hs_at     = -1;
        done      = 1'b0;
        mem_read       = rd;
        mem_write      = wr;
        address        = addr;
        write_data     = wdata;
        bus_req_ready  = (ready_dly == 0);
        bus_resp_valid = 1'b0;
        bus_resp_rdata = rdata;
        bus_resp_err   = resp_err;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (lsu_stall) stall_cyc++;
            if (bus_req_valid) begin
                if (bus_req_addr !== {addr[31:2], 2'b00} || bus_req_wdata !== wdata ||
                    bus_req_we !== wr)
                    stable_ok = 1'b0;
                if (bus_req_ready) begin
                    hs_cnt++;
                    hs_at = k;
                end
                reqv_cyc++;
            end
            if (!lsu_stall) done = 1'b1;
            @(posedge clk);
            #1;
            bus_req_ready  = (reqv_cyc >= ready_dly);
            bus_resp_valid = resp_en && (hs_at >= 0) && (k == hs_at);
        end
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL access_completion: got no DONE within 200 cycles expected DONE");
        end
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        bus_req_ready  = 1'b0;
        bus_resp_valid = 1'b0;
        bus_resp_err   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  sc, hs, rv, c0, c1;
        bit  st;
        reset = 1'b1;
        mem_read = 1'b1; mem_write = 1'b0;
        address = 32'h14; write_data = 32'd0;
        bus_req_ready = 1'b0; bus_resp_valid = 1'b0;
        bus_resp_rdata = 32'd0; bus_resp_err = 1'b0;

        // Reset state, with an access pending to show the stall is forced low
        @(posedge clk); #1;
        @(negedge clk);
        check("reset_stall", 64'(lsu_stall), 64'd0);
        check("reset_outputs", 64'({bus_req_valid, load_valid, access_fault, bus_req_we}), 64'd0);
        check("reset_load_data", 64'(load_data), 64'd0);
        check("reset_req_addr", 64'(bus_req_addr), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        mem_read = 1'b0;
        @(posedge clk); #1;

        // 1: load 0x14 -> 0x6D, 3 stall cycles
        expect_done(1'b1, 1'b0, 32'h6D);
        run_access(1'b1, 1'b0, 32'h14, 32'd0, 0, 1'b1, 1'b0, 32'h6D, sc, hs, rv, st);
        check("load_stall_cycles", 64'(sc), 64'd3);
        check("load_handshakes", 64'(hs), 64'd1);
        check("load_req_stable", 64'(st), 64'd1);

        // 2: store with ready delayed 3 cycles, load_data untouched
        expect_done(1'b0, 1'b0, 32'h6D);
        run_access(1'b0, 1'b1, 32'h20, 32'hDEADBEEF, 3, 1'b1, 1'b0, 32'h5555_AAAA, sc, hs, rv, st);
        check("store_req_stable", 64'(st), 64'd1);
        check("store_req_cycles", 64'(rv), 64'd4);
        check("store_handshakes", 64'(hs), 64'd1);
        check("store_stall_cycles", 64'(sc), 64'd6);

        // 3: illegal accesses fault without a bus request
        expect_done(1'b0, 1'b1, 32'd0);
        run_access(1'b1, 1'b0, 32'h16, 32'd0, 0, 1'b1, 1'b0, 32'h1, sc, hs, rv, st);
        check("misaligned_no_req", 64'(rv), 64'd0);
        check("misaligned_stall", 64'(sc), 64'd1);
        expect_done(1'b0, 1'b1, 32'd0);
        run_access(1'b1, 1'b0, 32'h80, 32'd0, 0, 1'b1, 1'b0, 32'h1, sc, hs, rv, st);
        check("out_of_range_no_req", 64'(rv), 64'd0);
        check("out_of_range_stall", 64'(sc), 64'd1);
        expect_done(1'b0, 1'b1, 32'd0);
        run_access(1'b1, 1'b1, 32'h00, 32'h1234, 0, 1'b1, 1'b0, 32'h1, sc, hs, rv, st);
        check("rd_wr_no_req", 64'(rv), 64'd0);
        check("rd_wr_stall", 64'(sc), 64'd1);

        // 4: timeout, then a late response that must be ignored
        expect_done(1'b0, 1'b1, 32'd0);
        run_access(1'b1, 1'b0, 32'h40, 32'd0, 0, 1'b0, 1'b0, 32'h0, sc, hs, rv, st);
        check("timeout_stall_cycles", 64'(sc), 64'(T + 1));
        check("timeout_handshakes", 64'(hs), 64'd1);
        bus_resp_valid = 1'b1;
        bus_resp_rdata = 32'hFFFF_0000;
        @(negedge clk);
        check("late_resp_ignored", 64'({load_valid, access_fault, lsu_stall, bus_req_valid}), 64'd0);
        @(posedge clk); #1;
        bus_resp_valid = 1'b0;
        @(negedge clk);
        check("late_resp_no_pulse", 64'({load_valid, access_fault}), 64'd0);
        check("late_resp_data_held", 64'(load_data), 64'd0);
        @(posedge clk); #1;

        // 5: back-to-back loads, then an errored load that clears load_data
        expect_done(1'b1, 1'b0, 32'hA5A5_0001);
        c0 = cyc;
        run_access(1'b1, 1'b0, 32'h00, 32'd0, 0, 1'b1, 1'b0, 32'hA5A5_0001, sc, hs, rv, st);
        check("b2b_first_handshakes", 64'(hs), 64'd1);
        expect_done(1'b1, 1'b0, 32'h0000_0B02);
        c1 = cyc;
        run_access(1'b1, 1'b0, 32'h04, 32'd0, 0, 1'b1, 1'b0, 32'h0000_0B02, sc, hs, rv, st);
        check("b2b_second_handshakes", 64'(hs), 64'd1);
        check("b2b_spacing", 64'(c1 - c0), 64'd4);
        expect_done(1'b0, 1'b1, 32'd0);
        run_access(1'b1, 1'b0, 32'h08, 32'd0, 0, 1'b1, 1'b1, 32'h1234, sc, hs, rv, st);
        check("err_stall_cycles", 64'(sc), 64'd3);

        // 6: reset while waiting for the response
        mem_read = 1'b1; address = 32'h10; bus_req_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_test_req_valid", 64'(bus_req_valid), 64'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        bus_req_ready = 1'b0;
        @(negedge clk);
        check("rst_in_resp_stall", 64'(lsu_stall), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        mem_read = 1'b0;
        bus_resp_valid = 1'b1;
        bus_resp_rdata = 32'h99;
        @(negedge clk);
        check("rst_after_outputs", 64'({bus_req_valid, load_valid, access_fault, lsu_stall}), 64'd0);
        @(posedge clk); #1;
        bus_resp_valid = 1'b0;
        @(negedge clk);
        check("rst_resp_ignored", 64'({load_valid, access_fault}), 64'd0);
        check("rst_load_data", 64'(load_data), 64'd0);
        @(posedge clk); #1;

        expect_done(1'b1, 1'b0, 32'h77);
        run_access(1'b1, 1'b0, 32'h18, 32'd0, 0, 1'b1, 1'b0, 32'h77, sc, hs, rv, st);
        check("post_rst_stall_cycles", 64'(sc), 64'd3);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Load/store initiator for the MEM stage. Turns the EX/MEM register's single-cycle mem_read/mem_write into a valid/ready request plus response transaction to a multi-cycle word data memory.
- Holds lsu_stall while a transaction is in flight. The pipeline freezes PC, IF/ID, ID/EX and EX/MEM, and bubbles MEM/WB.
- Returns load data to the mem_to_reg path.
- Flags misaligned, out-of-range, errored and timed-out accesses.

Parameters:
- MEM_BYTES, 128, size of the data address space in bytes; any address >= MEM_BYTES is out of range.
- TIMEOUT_CYCLES, 64, number of cycles in REQ+RESP before the access is abandoned; must be >= 2.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high
- mem_read  input  1  EX/MEM memRead
- mem_write  input  1  EX/MEM memWrite
- address  input  32  EX/MEM ALU result
- write_data  input  32  EX/MEM store data
- lsu_stall  output  1  freeze upstream pipeline registers
- load_data  output  32  read data to the mem_to_reg mux
- load_valid  output  1  one-cycle pulse: load_data is valid this cycle
- access_fault  output  1  one-cycle pulse: access failed
- bus_req_valid  output  1  request valid
- bus_req_ready  input  1  responder accepts the request
- bus_req_we  output  1  1 = store, 0 = load
- bus_req_addr  output  32  word address (bits [1:0] = 0)
- bus_req_wdata  output  32  store data
- bus_resp_valid  input  1  response valid; single-cycle pulse, no back-pressure
- bus_resp_rdata  input  32  load data
- bus_resp_err  input  1  responder error, qualified by bus_resp_valid

Behaviour:
- Reset values (next edge with reset=1): state IDLE, timeout counter 0, all registered outputs 0. lsu_stall is forced to 0 while reset=1.
- Reset mid-transaction: abandon the access, drop bus_req_valid next cycle, ignore any later bus_resp_valid.
- States: IDLE, REQ, RESP, DONE.
- access_req = mem_read | mem_write.
- IDLE:
  - No access_req: stay in IDLE, lsu_stall=0.
  - mem_read and mem_write both 1, address[1:0]!=0, or address>=MEM_BYTES: no bus request. Go to DONE with access_fault=1, load_data=0, load_valid=0.
  - Legal access: capture address, write_data and we=mem_write into the request registers. Assert bus_req_valid next cycle, go to REQ.
  - lsu_stall=1 combinationally in the same cycle the legal access is seen.
- REQ:
  - bus_req_valid=1, lsu_stall=1.
  - addr, we and wdata stay stable until the handshake (bus_req_valid & bus_req_ready at a clock edge).
  - On handshake: bus_req_valid=0 next cycle, go to RESP.
- RESP:
  - lsu_stall=1; wait for bus_resp_valid.
  - The responder must not respond in the handshake cycle. bus_resp_valid seen in IDLE, REQ or DONE is ignored.
  - On bus_resp_valid with err=0: go to DONE. For a load, load_data=rdata and load_valid=1. For a store, load_valid=0 and load_data is unchanged.
  - On bus_resp_valid with err=1: go to DONE with access_fault=1, load_data=0.
- Timeout:
  - The counter increments every cycle in REQ/RESP and clears on entering REQ.
  - When the count equals TIMEOUT_CYCLES-1 and no handshake/response occurs that edge: force bus_req_valid=0, go to DONE with access_fault=1, load_data=0.
  - Response and timeout on the same edge: the response wins.
- DONE:
  - Exactly one cycle, lsu_stall=0, so the pipeline advances past the completed access.
  - load_valid/access_fault are high only this cycle. load_data holds until the next load completes.
  - Unconditionally return to IDLE; mem_read/mem_write are not examined in DONE, so there is no re-issue.
- Latency:
  - Load with ready=1 at first REQ cycle and response the cycle after: IDLE (access seen), REQ, RESP, DONE. 3 stall cycles; load_valid in the 4th cycle.
- Back-to-back memory instructions: the second access is seen in IDLE the cycle after DONE. Never more than one outstanding request.

Test Plan:
1. Load: address=0x14, ready held 1, resp_valid one cycle after handshake with rdata=0x6D → lsu_stall high 3 cycles; one load_valid pulse with load_data=0x6D; fault=0.
2. Store: address=0x20, write_data=0xDEADBEEF, ready delayed 3 cycles → req addr/wdata/we=1 stable across all wait cycles; one handshake; load_valid=0 after resp.
3. Faults: address=0x16 (misaligned), address=0x80 (out of range), both read and write set → no bus_req_valid; access_fault pulse the next cycle; lsu_stall only in the detect cycle.
4. Timeout: ready=1, resp never arrives → access_fault exactly TIMEOUT_CYCLES cycles after entering REQ; then IDLE. Late resp_valid after this → ignored.
5. Error and back-to-back: resp_err=1 on a load → fault, load_data=0. Two consecutive loads (0x00, 0x04) → two separate handshakes, one DONE cycle between them, correct data each.
6. Reset in RESP, then resp_valid arrives → bus_req_valid=0, no load_valid/fault; state IDLE; next access works normally.
